add_sub_2c_serial: RTL and testbench

Bit-serial two's-complement add/subtract unit with a start/done handshake. It computes op1+op2 or op1-op2 one bit per clock, LSB first, and reports carry and signed overflow with the same meaning as the combinational N-bit two's-complement adder. It is the area-lean sequential counterpart for datapaths that can tolerate N+1 cycles of latency. It is also used as a cycle-accurate reference when benching the parallel adder.

---
 rtl/add_sub_2c_serial.sv | 123 ++++++++++++
 tb/tb_add_sub_2c_serial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_2c_serial.sv
// Bit-serial two's-complement add/subtract, LSB first, with start/done handshake.
// One bit per clock; carry and signed overflow match an N-bit parallel adder.
module add_sub_2c_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  output logic [N-1:0] out,
  output logic         co,
  output logic         ov,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_res;
  logic           r_carry;
  logic [CW-1:0]  r_count;

  logic           w_sum;
  logic           w_cout;
  logic           w_accept;
  logic           w_last;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder slice on the current LSBs and the accept/terminal decodes
  always_comb begin
    w_sum    = 1'b0;
    w_cout   = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    w_sum    = r_a[0] ^ r_b[0] ^ r_carry;
    w_cout   = maj3(r_a[0], r_b[0], r_carry);
    // A new request may land in the DONE cycle so back-to-back runs take N+1 cycles.
    if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
      w_accept = start;
    end else begin
      w_accept = 1'b0;
    end
    if (r_count == LAST_BIT) begin
      w_last = 1'b1;
    end else begin
      w_last = 1'b0;
    end
  end

  // Control FSM, operand/result shifters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= {N{1'b0}};
      r_b     <= {N{1'b0}};
      r_res   <= {N{1'b0}};
      r_carry <= 1'b0;
      r_count <= {CW{1'b0}};
      out     <= {N{1'b0}};
      co      <= 1'b0;
      ov      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is addition of the inverted operand with carry-in 1.
      r_a     <= op1;
      r_b     <= sub ? ~op2 : op2;
      r_carry <= sub;
      r_count <= {CW{1'b0}};
      r_state <= S_SHIFT;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        S_SHIFT: begin
          r_a     <= {1'b0, r_a[N-1:1]};
          r_b     <= {1'b0, r_b[N-1:1]};
          r_res   <= {w_sum, r_res[N-1:1]};
          r_carry <= w_cout;
          if (w_last) begin
            out     <= {w_sum, r_res[N-1:1]};
            co      <= w_cout;
            ov      <= r_carry ^ w_cout;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_2c_serial.sv
// Self-checking bench: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed literal results.
module tb_add_sub_2c_serial;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] op1 = 4'd0;
  logic [N-1:0] op2 = 4'd0;
  logic [N-1:0] out;
  logic         co, ov, busy, done;

  int checks = 0;
  int failures = 0;

  add_sub_2c_serial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op1(op1), .op2(op2),
    .out(out), .co(co), .ov(ov), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ov, co, out} from signed/unsigned integer arithmetic
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic s);
    int sa, sb, t, ua, ub;
    logic [31:0] tt;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    t  = s ? (sa - sb) : (sa + sb);
    tt = t;
    c  = s ? (ua >= ub) : ((ua + ub) >= (1 << N));
    v  = (t < -(1 << (N - 1))) || (t > (1 << (N - 1)) - 1);
    return {v, c, tt[N-1:0]};
  endfunction

  int           m_cnt = 0;
  logic [N-1:0] m_out = 4'd0, p_out = 4'd0;
  logic         m_co = 1'b0, m_ov = 1'b0, p_co = 1'b0, p_ov = 1'b0;
  int           m_dones = 0, d_dones = 0;

  // Model: m_cnt is cycles since accept (0 = idle, N+1 = done cycle)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_out <= 4'd0;
      m_co  <= 1'b0;
      m_ov  <= 1'b0;
    end else if ((m_cnt == 0 || m_cnt == N + 1) && start) begin
      m_cnt <= 1;
      {p_ov, p_co, p_out} <= ref_op(op1, op2, sub);
    end else if (m_cnt >= 1 && m_cnt <= N) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == N) begin
        m_out <= p_out;
        m_co  <= p_co;
        m_ov  <= p_ov;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
    chk("done", {31'd0, done}, {31'd0, m_cnt == N + 1});
    chk("out",  {28'd0, out},  {28'd0, m_out});
    chk("co",   {31'd0, co},   {31'd0, m_co});
    chk("ov",   {31'd0, ov},   {31'd0, m_ov});
    if (done === 1'b1) d_dones++;
    if (m_cnt == N + 1) m_dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [N-1:0] eo, input logic ec, input logic ev);
    int got;
    got = 0;
    op1 = a; op2 = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    op1 = ~a; op2 = ~b; sub = ~s;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done === 1'b1) begin
        got = k;
        break;
      end
    end
    chk("latency", got, N);
    chk("lit_out", {28'd0, out}, {28'd0, eo});
    chk("lit_co",  {31'd0, co},  {31'd0, ec});
    chk("lit_ov",  {31'd0, ov},  {31'd0, ev});
    tick();
    chk("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int bb_dones;
    logic [N-1:0] va [8];
    logic [N-1:0] vb [8];
    va = '{4'b0001, 4'b1111, 4'b1000, 4'b0111, 4'b0110, 4'b1000, 4'b0111, 4'b0101};
    vb = '{4'b0011, 4'b1111, 4'b1000, 4'b0111, 4'b0111, 4'b0001, 4'b0111, 4'b1010};
    #1 rst = 1'b1;
    tick();
    chk("rst_out",  {28'd0, out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_op(4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0);
    do_op(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
    do_op(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    do_op(4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b1);
    do_op(4'b0110, 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b0);
    do_op(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
    do_op(4'b0111, 4'b0111, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted
    op1 = 4'b0001; op2 = 4'b0011; sub = 1'b0; start = 1'b1;
    tick();                                   // T
    start = 1'b0;
    tick();                                   // T+1
    op1 = 4'b0111; op2 = 4'b0111; start = 1'b1;
    tick();                                   // T+2
    start = 1'b0;
    tick();                                   // T+3
    chk("ign_nodone", {31'd0, done}, 32'd0);
    tick();                                   // T+4
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_out", {28'd0, out}, 32'd4);
    op1 = 4'b0010; op2 = 4'b0011; start = 1'b1;
    tick();                                   // T+5
    start = 1'b0;
    chk("acc_busy", {31'd0, busy}, 32'd1);
    chk("acc_nodone", {31'd0, done}, 32'd0);
    tick(); tick(); tick();                   // T+8
    chk("acc_nodone2", {31'd0, done}, 32'd0);
    tick();                                   // T+9
    chk("acc_done", {31'd0, done}, 32'd1);
    chk("acc_out", {28'd0, out}, 32'd5);
    tick(); tick();

    // Reset mid-operation
    op1 = 4'b0111; op2 = 4'b0111; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_out",  {28'd0, out}, 32'd0);
    chk("abort_co",   {31'd0, co},  32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    do_op(4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0);

    // Back-to-back with start held high and vectors changing every cycle
    bb_dones = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op1 = va[i % 8];
      op2 = vb[i % 8];
      sub = i[1];
      tick();
      if (done === 1'b1) bb_dones++;
    end
    start = 1'b0;
    chk("b2b_dones", bb_dones, 6);
    repeat (7) tick();

    chk("done_total", d_dones, m_dones);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
